// File: rtl/memory_p.sv
// Shared board geometry and FSM state encoding for the line-clear engine.
package memory_p;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 20;
  localparam int ROWID_W    = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    CLEAR,
    DONE
  } lc_state_t;
endpackage

// File: rtl/line_clear.sv
// Line-clear engine: compacts non-full rows toward the bottom of the board,
// zero-fills the vacated top rows, and keeps last-pass and running line counts.
module line_clear #(
  parameter int BOARD_ROWS = memory_p::BOARD_ROWS,
  parameter int BOARD_COLS = memory_p::BOARD_COLS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            lines_cleared,
  output logic [15:0]           total_lines,
  output logic                  wnr,
  output logic [4:0]            rowid,
  output logic [BOARD_COLS-1:0] wdata,
  input  logic [BOARD_COLS-1:0] rdata
);
  import memory_p::*;

  localparam logic [ROWID_W-1:0] LAST = ROWID_W'(BOARD_ROWS - 1);
  localparam logic [ROWID_W-1:0] ONE  = ROWID_W'(1);

  lc_state_t             state_q;
  logic [ROWID_W-1:0]    src_q, dst_q, rowid_q;
  logic [4:0]            cnt_q, clr_q, lines_q;
  logic [15:0]           total_q;
  logic [BOARD_COLS-1:0] row_q;
  logic                  busy_q, done_q, wnr_q;

  logic                  row_full;
  logic [16:0]           tot_sum;
  logic [15:0]           tot_sat;

  assign row_full = (rdata == {BOARD_COLS{1'b1}});
  assign tot_sum  = {1'b0, total_q} + {12'b0, cnt_q};
  assign tot_sat  = tot_sum[16] ? 16'hFFFF : tot_sum[15:0];

  // Outputs are registered: every branch sets up the bus values the next state needs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rowid_q <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wnr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= LAST;
            dst_q   <= LAST;
            cnt_q   <= '0;
            rowid_q <= LAST;
            wnr_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          row_q <= rdata;
          if (row_full) begin
            cnt_q <= cnt_q + 5'd1;
            if (src_q != '0) begin
              src_q   <= src_q - ONE;
              rowid_q <= src_q - ONE;
            end else begin
              // A full row at src 0 always leaves at least one row to clear.
              clr_q   <= cnt_q + 5'd1;
              rowid_q <= dst_q;
              row_q   <= '0;
              wnr_q   <= 1'b1;
              state_q <= CLEAR;
            end
          end else begin
            rowid_q <= dst_q;
            wnr_q   <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          dst_q <= dst_q - ONE;
          row_q <= '0;
          if (src_q != '0) begin
            src_q   <= src_q - ONE;
            rowid_q <= src_q - ONE;
            wnr_q   <= 1'b0;
            state_q <= READ;
          end else if (cnt_q != '0) begin
            clr_q   <= cnt_q;
            rowid_q <= dst_q - ONE;
            state_q <= CLEAR;
          end else begin
            wnr_q   <= 1'b0;
            done_q  <= 1'b1;
            lines_q <= cnt_q;
            total_q <= tot_sat;
            state_q <= DONE;
          end
        end
        CLEAR: begin
          if (clr_q == 5'd1) begin
            wnr_q   <= 1'b0;
            done_q  <= 1'b1;
            lines_q <= cnt_q;
            total_q <= tot_sat;
            state_q <= DONE;
          end else begin
            clr_q   <= clr_q - 5'd1;
            rowid_q <= rowid_q - ONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          rowid_q <= '0;
          row_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign wnr           = wnr_q;
  assign rowid         = rowid_q;
  assign wdata         = row_q;
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;
endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear with a behavioural board and a result scoreboard.
module tb_line_clear;
  localparam int R = 20;
  localparam int C = 20;
  localparam logic [C-1:0] ALL = '1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, wnr;
  logic [4:0]   rowid, lines_cleared;
  logic [15:0]  total_lines;
  logic [C-1:0] wdata, rdata;

  always #5 clk = ~clk;

  line_clear #(.BOARD_ROWS(R), .BOARD_COLS(C)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .total_lines(total_lines), .wnr(wnr),
    .rowid(rowid), .wdata(wdata), .rdata(rdata)
  );

  // Board: combinational read, synchronous write; a side port preloads images.
  logic [C-1:0] board [R];
  logic         ld_en = 1'b0;
  logic [4:0]   ld_row = '0;
  logic [C-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) board[ld_row] <= ld_data;
    else if (wnr && rowid < 5'(R)) board[rowid] <= wdata;
  end
  assign rdata = (rowid < 5'(R)) ? board[rowid] : '0;

  typedef struct packed {
    logic [R-1:0][C-1:0] rows;
    logic [4:0]          lines;
    logic [15:0]         total;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [R-1:0][C-1:0] img);
    for (int r = 0; r < R; r++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_row = 5'(r); ld_data = img[r];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_pass(input string name, input logic [R-1:0][C-1:0] img, input bit pulse_mid);
    exp_t e;
    int k, n, nbusy, ndone;
    bit fin;
    load(img);
    e.rows = '0; k = R - 1; n = 0;
    for (int r = R - 1; r >= 0; r--) begin
      if (img[r] == ALL) n++;
      else begin e.rows[k] = img[r]; k--; end
    end
    exp_total = exp_total + n;
    if (exp_total > 65535) exp_total = 65535;
    e.lines = 5'(n);
    e.total = 16'(exp_total);
    sb.push_back(e);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    nbusy = 0; ndone = 0; fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        check({name, "_wnr_in_done"}, 32'(wnr), 0);
      end
      if (!busy) fin = 1'b1;
      else begin
        start = pulse_mid && (nbusy == 5);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({name, "_finished"}, 32'(fin), 1);
    check({name, "_busy_cycles"}, nbusy, 41);
    check({name, "_done_pulses"}, ndone, 1);

    e = sb.pop_front();
    check({name, "_lines"}, 32'(lines_cleared), 32'(e.lines));
    check({name, "_total"}, 32'(total_lines), 32'(e.total));
    check({name, "_idle_wnr"}, 32'(wnr), 0);
    check({name, "_idle_rowid"}, 32'(rowid), 0);
    check({name, "_idle_wdata"}, 32'(wdata), 0);
    for (int r = 0; r < R; r++)
      check($sformatf("%s_row%0d", name, r), 32'(board[r]), 32'(e.rows[r]));
  endtask

  initial begin
    logic [R-1:0][C-1:0] img;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wnr", 32'(wnr), 0);
    check("rst_rowid", 32'(rowid), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_lines", 32'(lines_cleared), 0);
    check("rst_total", 32'(total_lines), 0);
    reset_n = 1'b1;

    img = '0;
    run_pass("empty", img, 1'b0);

    img = '0; img[19] = ALL; img[18] = 20'h00001;
    run_pass("one", img, 1'b0);

    img = '0; img[19] = ALL; img[17] = ALL; img[18] = 20'hABCDE; img[16] = 20'h12345;
    run_pass("two", img, 1'b0);

    for (int r = 0; r < R; r++) img[r] = ALL;
    run_pass("all", img, 1'b0);

    // Preload the running total near saturation; then a 4-line pass with a stray start.
    @(negedge clk);
    force dut.total_q = 16'hFFFE;
    @(negedge clk);
    release dut.total_q;
    exp_total = 16'hFFFE;
    check("preload_total", 32'(total_lines), 32'hFFFE);
    for (int r = 0; r < R; r++) img[r] = 20'($urandom) & 20'hFFFFE;
    img[0] = ALL; img[5] = ALL; img[10] = ALL; img[19] = ALL;
    run_pass("sat", img, 1'b1);

    // Abort a pass with reset, then confirm a clean pass afterwards.
    img = '0; img[19] = ALL; img[3] = 20'h0F0F0;
    load(img);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_wnr", 32'(wnr), 0);
    check("abort_done", 32'(done), 0);
    check("abort_lines", 32'(lines_cleared), 0);
    check("abort_total", 32'(total_lines), 0);
    exp_total = 0;
    @(negedge clk) reset_n = 1'b1;

    img = '0; img[19] = ALL; img[12] = ALL; img[7] = 20'h5A5A5; img[0] = 20'h80001;
    run_pass("after_rst", img, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 The block SHALL have parameter BOARD_ROWS, default 20, meaning the number of board rows; row 0 is the top and row BOARD_ROWS-1 is the bottom.
REQ-002 The block SHALL have parameter BOARD_COLS, default 20, meaning the number of bits per row.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to run one clear pass.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a pass.
REQ-008 The block SHALL have port lines_cleared, output, 5 bits: the full-row count of the last pass.
REQ-009 The block SHALL have port total_lines, output, 16 bits: the saturating running total of cleared rows.
REQ-010 The block SHALL have port wnr, output, 1 bit: the board write enable (1 = write).
REQ-011 The block SHALL have port rowid, output, 5 bits: the board row address.
REQ-012 The block SHALL have port wdata, output, BOARD_COLS bits: the board write data, driving the board's in port.
REQ-013 The block SHALL have port rdata, input, BOARD_COLS bits: the board's combinational read data for the current rowid.

Function
REQ-014 The FSM SHALL have states IDLE, READ, WRITE, CLEAR, DONE.
REQ-015 In IDLE, start=1 SHALL load src=dst=BOARD_ROWS-1, clear the pass count to 0 and go to READ; start SHALL be ignored in all other states.
REQ-016 In READ, the block SHALL drive rowid=src and wnr=0, and capture rdata into row_q.
REQ-017 A row SHALL be full iff rdata equals all ones; a full row increments the pass count and is not written back.
REQ-018 From READ, a non-full row SHALL go to WRITE; a full row SHALL go to READ with src-1 when src≠0, otherwise to the scan-end transition.
REQ-019 In WRITE, the block SHALL drive rowid=dst, wnr=1, wdata=row_q, then decrement dst and go to READ with src-1, or to the scan-end transition when src=0.
REQ-020 WRITE SHALL occur even when dst=src, so that latency is data-independent.
REQ-021 At scan end, the block SHALL go to CLEAR if pass count>0, else to DONE.
REQ-022 CLEAR SHALL write zeros to rows dst, dst-1, … for exactly pass-count cycles (wnr=1, wdata=0), then go to DONE.
REQ-023 Termination SHALL use the src==0 test and a down-counter; index underflow SHALL never be used.
REQ-024 DONE SHALL assert done for 1 cycle, update lines_cleared, add the pass count to total_lines (saturating at 16'hFFFF) and return to IDLE.
REQ-025 A pass SHALL take exactly BOARD_ROWS+BOARD_ROWS cycles in READ/WRITE/CLEAR (40 at default) plus 1 DONE cycle; busy SHALL be high for 41 cycles.
REQ-026 wnr SHALL be 0 in IDLE, READ and DONE; rowid and wdata SHALL be 0 in IDLE.
REQ-027 lines_cleared SHALL hold its value between passes.

Reset
REQ-028 reset_n low SHALL immediately force IDLE and set busy, done, wnr, rowid, wdata, lines_cleared and total_lines to 0.
REQ-029 A reset mid-pass SHALL abort the pass with no further writes; board contents are then undefined unless the board is reset too.

Structure
REQ-030 Package memory_p SHALL hold BOARD_ROWS, BOARD_COLS, ROWID_W=5 and the enum lc_state_t.
REQ-031 No sub-module SHALL be used; the block SHALL instantiate alongside board, sharing clk and reset_n.

Verification
REQ-032 Empty board, start -> busy for 41 cycles, done pulse, lines_cleared=0, board unchanged.
REQ-033 Row 19 full, row 18=20'h00001 -> row 19=20'h00001, row 0=0, lines_cleared=1.
REQ-034 Rows 19,17 full, row 18=20'hABCDE, row 16=20'h12345 -> row19=ABCDE, row18=12345, rows 0-1 zero, lines_cleared=2.
REQ-035 All 20 rows full -> all rows 0, lines_cleared=20, still 41 busy cycles.
REQ-036 start pulsed while busy -> ignored; exactly one done; total_lines preloaded at 16'hFFFE plus a 4-line pass -> total_lines=16'hFFFF.
REQ-037 reset_n low at cycle 10 of a pass -> busy=0, wnr=0 the same cycle; next start runs a clean pass.
